// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin shared 16-bit binary-to-BCD converter
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      synchronous active-high reset
//   req        per-requester conversion request (level)
//   data       operands, requester i on [16*i+15:16*i]
//   ack        one-hot one-cycle pulse: request accepted, operand captured
//   busy       engine occupied
//   out_valid  one-cycle pulse: BCD0..BCD4/out_id updated
//   out_id     requester owning the current result
//   BCD0..BCD4 units..ten-thousands digits, held until next result
module bcd_convert_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   data,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic                 out_valid,
    output logic [IDW-1:0]       out_id,
    output logic [3:0]           BCD0,
    output logic [3:0]           BCD1,
    output logic [3:0]           BCD2,
    output logic [3:0]           BCD3,
    output logic [3:0]           BCD4
);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t         state;
    logic [IDW-1:0] last;
    logic [3:0]     count;
    logic [35:0]    sr;

    logic           found;
    logic [IDW-1:0] win;
    logic [35:0]    sr_adj;
    logic [35:0]    sr_shift;

    // Round-robin pick: first requester at or after last+1, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Add-3 on the four low digit fields; the top digit can never reach 5
    // before the final shift, so it is left alone.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < 4; d++) begin
            if (sr[16+4*d +: 4] >= 4'd5)
                sr_adj[16+4*d +: 4] = sr[16+4*d +: 4] + 4'd3;
        end
        sr_shift = {sr_adj[34:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            count     <= 4'd0;
            sr        <= 36'd0;
            ack       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            BCD0      <= 4'd0;
            BCD1      <= 4'd0;
            BCD2      <= 4'd0;
            BCD3      <= 4'd0;
            BCD4      <= 4'd0;
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sr    <= {20'd0, data[16*win +: 16]};
                        ack   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        last  <= win;
                        count <= 4'd0;
                        busy  <= 1'b1;
                        state <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr    <= sr_shift;
                    count <= count + 4'd1;
                    if (count == 4'd15) begin
                        BCD0      <= sr_shift[19:16];
                        BCD1      <= sr_shift[23:20];
                        BCD2      <= sr_shift[27:24];
                        BCD3      <= sr_shift[31:28];
                        BCD4      <= sr_shift[35:32];
                        out_id    <= last;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
